// File: rtl/ysyx_23060191_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding request, round-robin on ties,
// response routed back to its owner, stalled transactions terminated by a timeout.
//   state  | meaning
//   S_IDLE | no transaction; grant evaluated combinationally
//   S_REQ  | mem_req_valid held until mem_req_ready
//   S_WAIT | request taken by memory, waiting for mem_rsp_valid
module ysyx_23060191_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Loaded on accept so that terminal count lands on the cycle TIMEOUT_CYC-1 after accept.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]        state;
  logic              last;
  logic              owner;
  logic              run;
  logic [TW-1:0]     timer;
  logic              gnt_ifu;
  logic              gnt_lsu;
  logic              accept;
  logic              busy;
  logic              complete;
  logic              timeout;
  logic [DATA_W-1:0] rsp_word;

  // run keeps both readies low while reset is asserted and for the first cycle after release.
  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    if (run && state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        gnt_lsu = (last == OWN_IFU);
        gnt_ifu = (last == OWN_LSU);
      end else begin
        gnt_ifu = ifu_req_valid;
        gnt_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;
  assign accept        = gnt_ifu | gnt_lsu;

  assign busy     = (state == S_REQ) || (state == S_WAIT);
  assign complete = mem_rsp_valid && ((state == S_WAIT) || (state == S_REQ && mem_req_ready));
  assign timeout  = busy && !complete && (timer == '0);
  assign rsp_word = (complete && !mem_req_wen) ? mem_rsp_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      last          <= OWN_IFU;
      owner         <= OWN_IFU;
      run           <= 1'b0;
      timer         <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      run           <= 1'b1;
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_data  <= '0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_data  <= '0;
      lsu_rsp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_REQ;
            owner         <= gnt_lsu;
            last          <= gnt_lsu;
            timer         <= TMO_LOAD;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= gnt_lsu ? lsu_req_addr : ifu_req_addr;
            mem_req_wen   <= gnt_lsu & lsu_req_wen;
            mem_req_wdata <= gnt_lsu ? lsu_req_wdata : '0;
            mem_req_wmask <= gnt_lsu ? lsu_req_wmask : '0;
          end
        end
        S_REQ, S_WAIT: begin
          if (complete || timeout) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            if (owner == OWN_LSU) begin
              lsu_rsp_valid <= 1'b1;
              lsu_rsp_data  <= rsp_word;
              lsu_rsp_err   <= timeout;
            end else begin
              ifu_rsp_valid <= 1'b1;
              ifu_rsp_data  <= rsp_word;
              ifu_rsp_err   <= timeout;
            end
          end else begin
            timer <= timer - 1'b1;
            if (state == S_REQ && mem_req_ready) begin
              state         <= S_WAIT;
              mem_req_valid <= 1'b0;
            end
          end
        end
        default: begin
          state         <= S_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (busy flag, age counter, last owner).
module tb_ysyx_23060191_mem_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr = '0;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr = '0;
  logic        lsu_req_wen = 1'b0;
  logic [31:0] lsu_req_wdata = '0;
  logic [3:0]  lsu_req_wmask = '0;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  ysyx_23060191_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_req_wen = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [6:0]   ctl;
    logic [136:0] dat;
    rstn = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    tick();
    ctl = {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_rsp_err, lsu_rsp_err};
    dat = {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask, ifu_rsp_data, lsu_rsp_data};
    n_checks++;
    if (ctl !== '0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
    n_checks++;
    if (dat !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", dat); end
    clear_inputs();
    rstn = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 000", {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid});
    end
  endtask

  task automatic test_ifu_basic();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL ifu_grant: got %b expected 10", {ifu_req_ready, lsu_req_ready});
    end
    tick();
    ifu_req_valid = 1'b0;
    n_checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
      n_fail++; $display("FAIL ifu_mem_req: got v=%b a=%h w=%b expected v=1 a=80000000 w=0", mem_req_valid, mem_req_addr, mem_req_wen);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413;
    tick();
    clear_inputs();
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid, mem_req_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ifu_rsp: got v=%b d=%h e=%b lv=%b expected v=1 d=00000413 e=0 lv=0", ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err, lsu_rsp_valid);
    end
    tick();
    n_checks++;
    if (ifu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ifu_rsp_pulse: got %b expected 0", ifu_rsp_valid); end
  endtask

  task automatic test_tie_rr();
    logic exp_lsu;
    reset_dut();
    exp_lsu = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000 + 32'(i * 4);
      lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_2000 + 32'(i * 4); lsu_req_wen = 1'b0;
      #1;
      n_checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
        n_fail++; $display("FAIL tie_grant[%0d]: got %b expected %b", i, {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
      end
      tick();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'(i + 100);
      tick();
      clear_inputs();
      n_checks++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_lsu, exp_lsu}) begin
        n_fail++; $display("FAIL tie_owner[%0d]: got %b expected %b", i, {ifu_rsp_valid, lsu_rsp_valid}, {~exp_lsu, exp_lsu});
      end
      exp_lsu = ~exp_lsu;
    end
    tick();
  endtask

  task automatic test_store_stall();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1'b1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 4'hF;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin n_fail++; $display("FAIL store_grant: got %b expected 1", lsu_req_ready); end
    tick();
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0; lsu_req_wen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !==
          {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
        n_fail++; $display("FAIL store_hold[%0d]: got v=%b a=%h d=%h m=%h expected v=1 a=80001000 d=deadbeef m=f",
                           k, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask);
      end
      mem_req_ready = (k == 3);
      tick();
    end
    mem_req_ready = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL store_drop: got %b expected 0", mem_req_valid); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    n_checks++;
    if ({lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err, ifu_rsp_valid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL store_rsp: got v=%b d=%h e=%b expected v=1 d=00000000 e=0", lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0040;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      n_checks++;
      if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, lsu_rsp_valid} !== {(k == T), (k == T), 32'h0, 1'b0}) begin
        n_fail++; $display("FAIL timeout[+%0d]: got v=%b e=%b d=%h expected v=%0d e=%0d d=0",
                           k, ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, (k == T), (k == T));
      end
      if (k == T) begin
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_memv: got %b expected 0", mem_req_valid); end
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = (k == T + 2);
      mem_rsp_data = 32'h5555_AAAA;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_wait();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0100;
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; lsu_req_valid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_req_addr, ifu_rsp_valid, lsu_rsp_valid} !== '0) begin
      n_fail++; $display("FAIL reset_wait: got memv=%b addr=%h lrdy=%b expected all 0", mem_req_valid, mem_req_addr, lsu_req_ready);
    end
    tick();
    clear_inputs();
    rstn = 1'b1;
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0200;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_grant: got %b expected 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
    tick();
    clear_inputs();
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
      n_fail++; $display("FAIL post_reset_rsp: got v=%b d=%h e=%b expected v=1 d=cafe0001 e=0", ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h8000_3000; lsu_req_wen = 1'b0;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    tick();
    clear_inputs();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0300;
    #1;
    n_checks++;
    if ({lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err} !== {1'b1, 32'h1234_5678, 1'b0}) begin
      n_fail++; $display("FAIL same_cycle_rsp: got v=%b d=%h e=%b expected v=1 d=12345678 e=0", lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err);
    end
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin n_fail++; $display("FAIL same_cycle_regrant: got %b expected 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_F00D;
    tick();
    clear_inputs();
    n_checks++;
    if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL same_cycle_next: got v=%b d=%h expected v=1 d=0badf00d", ifu_rsp_valid, ifu_rsp_data);
    end
    tick();
  endtask

  // Transaction-level model: a transaction lives from accept until response or its age reaches T-1.
  task automatic test_random();
    logic        busy, owner_lsu, store, taken, last_lsu, g_ifu, g_lsu;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wmask;
    int          age;
    logic        e_iv, e_ie, e_lv, e_le;
    logic [31:0] e_id, e_ld;
    reset_dut();
    busy = 0; owner_lsu = 0; store = 0; taken = 0; last_lsu = 0; age = 0;
    t_addr = '0; t_wdata = '0; t_wmask = '0;
    e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0; e_id = '0; e_ld = '0;
    for (int c = 0; c < 3000; c++) begin
      n_checks++;
      if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data} !==
          {e_iv, e_ie, e_id, e_lv, e_le, e_ld}) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got i=%b/%b/%h l=%b/%b/%h expected i=%b/%b/%h l=%b/%b/%h", c,
                           ifu_rsp_valid, ifu_rsp_err, ifu_rsp_data, lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data,
                           e_iv, e_ie, e_id, e_lv, e_le, e_ld);
      end
      n_checks++;
      if (mem_req_valid !== (busy && !taken)) begin
        n_fail++; $display("FAIL rnd_memv[%0d]: got %b expected %b", c, mem_req_valid, busy && !taken);
      end
      if (busy && !taken) begin
        n_checks++;
        if ({mem_req_addr, mem_req_wen, mem_req_wmask} !== {t_addr, store, t_wmask} ||
            (store && mem_req_wdata !== t_wdata)) begin
          n_fail++; $display("FAIL rnd_memreq[%0d]: got a=%h w=%b m=%h d=%h expected a=%h w=%b m=%h d=%h", c,
                             mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata, t_addr, store, t_wmask, t_wdata);
        end
      end
      ifu_req_valid = ($urandom_range(0, 2) == 0);
      ifu_req_addr  = $urandom;
      lsu_req_valid = ($urandom_range(0, 2) == 0);
      lsu_req_addr  = $urandom;
      lsu_req_wen   = $urandom_range(0, 1);
      lsu_req_wdata = $urandom;
      lsu_req_wmask = 4'($urandom);
      mem_req_ready = $urandom_range(0, 1);
      mem_rsp_valid = ($urandom_range(0, 4) == 0);
      mem_rsp_data  = $urandom;
      #1;
      g_ifu = !busy && ifu_req_valid && (!lsu_req_valid || last_lsu);
      g_lsu = !busy && lsu_req_valid && (!ifu_req_valid || !last_lsu);
      n_checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {g_ifu, g_lsu}) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", c, {ifu_req_ready, lsu_req_ready}, {g_ifu, g_lsu});
      end
      e_iv = 0; e_ie = 0; e_lv = 0; e_le = 0; e_id = '0; e_ld = '0;
      if (busy) begin
        if (mem_rsp_valid && (taken || mem_req_ready)) begin
          if (owner_lsu) begin e_lv = 1; e_ld = store ? 32'h0 : mem_rsp_data; end
          else begin e_iv = 1; e_id = mem_rsp_data; end
          busy = 0;
        end else if (age == T - 1) begin
          if (owner_lsu) begin e_lv = 1; e_le = 1; end
          else begin e_iv = 1; e_ie = 1; end
          busy = 0;
        end else begin
          if (mem_req_ready) taken = 1;
          age++;
        end
      end else if (g_ifu || g_lsu) begin
        busy = 1; age = 1; taken = 0;
        owner_lsu = g_lsu; last_lsu = g_lsu;
        store   = g_lsu && lsu_req_wen;
        t_addr  = g_lsu ? lsu_req_addr : ifu_req_addr;
        t_wdata = lsu_req_wdata;
        t_wmask = g_lsu ? lsu_req_wmask : 4'h0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tie_rr();
    test_ifu_basic();
    test_store_stall();
    test_timeout();
    test_reset_in_wait();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
